// File: rtl/wb_stage_if.sv
// MINAv2 writeback-stage bus: writeback payload type plus the MEM/ID/EX-facing signal bundle.
// master = surrounding pipeline, slave = wb_stage.
package wb_stage_pkg;
  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
  } wb_params_t;
endpackage

interface wb_stage_if #(parameter int CNT_W = 32) ();
  import wb_stage_pkg::*;

  logic             stall;
  logic             flush;
  logic             mem_valid;
  wb_params_t       wb_params;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [31:0]      rs1_data;
  logic [31:0]      rs2_data;
  logic             fwd_valid;
  logic [4:0]       fwd_rd_addr;
  logic [31:0]      fwd_rd_data;
  logic [CNT_W-1:0] retired;

  modport master (
    output stall, flush, mem_valid, wb_params, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, fwd_valid, fwd_rd_addr, fwd_rd_data, retired
  );

  modport slave (
    input  stall, flush, mem_valid, wb_params, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, fwd_valid, fwd_rd_addr, fwd_rd_data, retired
  );
endinterface

// File: rtl/wb_stage.sv
// MINAv2 writeback stage: MEM/WB register, 32x32 regfile with two combinational read ports, retire counter.
// Define WB_BYPASS_EN to forward the MEM/WB entry straight onto the read ports.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter int RESET_REGFILE = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  wb_stage_if.slave wb
);

  logic             v_q, v_d;
  logic [4:0]       rd_addr_q, rd_addr_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      regs_q [32];
  logic             wr_en;

  // flush beats stall; a bubble carries rd_addr=0 so it can never write.
  always_comb begin
    v_d       = v_q;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (wb.flush) begin
      v_d       = 1'b0;
      rd_addr_d = '0;
      rd_data_d = '0;
    end else if (!wb.stall) begin
      v_d       = wb.mem_valid;
      rd_addr_d = wb.mem_valid ? wb.wb_params.rd_addr : 5'd0;
      rd_data_d = wb.wb_params.rd_data;
    end
  end

  assign wr_en = v_q && (rd_addr_q != 5'd0);
  assign cnt_d = (v_q && !wb.stall) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q       <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      v_q       <= v_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      cnt_q     <= cnt_d;
    end
  end

  // Rewrites while stalled store the same value again, so no stall gating is needed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if (RESET_REGFILE != 0) begin
        for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[rd_addr_q] <= rd_data_q;
    end
  end

`ifdef WB_BYPASS_EN
  assign wb.rs1_data = (wb.rs1_addr == 5'd0) ? 32'd0 :
                       (wr_en && wb.rs1_addr == rd_addr_q) ? rd_data_q : regs_q[wb.rs1_addr];
  assign wb.rs2_data = (wb.rs2_addr == 5'd0) ? 32'd0 :
                       (wr_en && wb.rs2_addr == rd_addr_q) ? rd_data_q : regs_q[wb.rs2_addr];
`else
  assign wb.rs1_data = (wb.rs1_addr == 5'd0) ? 32'd0 : regs_q[wb.rs1_addr];
  assign wb.rs2_data = (wb.rs2_addr == 5'd0) ? 32'd0 : regs_q[wb.rs2_addr];
`endif

  assign wb.fwd_valid   = wr_en;
  assign wb.fwd_rd_addr = rd_addr_q;
  assign wb.fwd_rd_data = rd_data_q;
  assign wb.retired     = cnt_q;

endmodule
